fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Control unit for the IF stage. Drives the PC register enable and the next-PC mux select.
//  Sequences boot after reset and arbitrates between sequential fetch, hazard stalls,
//  branch/jump redirects from ID and instruction-memory wait states.
//  Holds a redirect that cannot be taken immediately until the PC may advance.
//  Sits between the hazard unit / ID branch logic and the IF datapath (PC reg, PC+4 adder, jump MUX).
// PARAMETERS
//  ADDR_W       32           PC / jump address width
//  BOOT_CYCLES  2            cycles PC is held after reset release (imem warm-up), >=1
//  CNT_W        32           width of perf counters (PERF_CNT_EN only)
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       synchronous, active-low reset (0 = reset)
//  stall           in   1       hazard unit: freeze PC and IF/ID this cycle
//  redirect_valid  in   1       ID: branch taken / jump resolved this cycle
//  redirect_addr   in   ADDR_W  ID: redirect target
//  imem_ready      in   1       instruction memory returns valid Inst this cycle
//  PC_enable       out  1       PC register write enable
//  PC_jump_select  out  1       0 = PC4, 1 = jump_addr
//  jump_addr       out  ADDR_W  redirect target presented to the PC MUX
//  ifid_enable     out  1       IF/ID pipeline register write enable
//  ifid_clear      out  1       load a bubble (nop) into IF/ID
//  redirect_pend   out  1       a redirect is latched and awaiting issue
//  stall_cnt       out  CNT_W   PERF_CNT_EN only: cycles with PC_enable==0 outside BOOT
//  redirect_cnt    out  CNT_W   PERF_CNT_EN only: redirects issued to the PC
// BEHAVIOUR
//  - States: BOOT, RUN, PEND. Registered: state, boot_cnt, pend_addr. All other outputs combinational.
//  - reset==0 at clk edge: state=BOOT, boot_cnt=0, pend_addr=0, perf counters=0.
//    While in BOOT all outputs are 0 except ifid_clear=1.
//  - BOOT: boot_cnt increments each cycle. At boot_cnt==BOOT_CYCLES-1 -> RUN.
//    Stall and redirect inputs are ignored.
//  - adv = imem_ready & ~stall. PC_enable = adv in RUN/PEND.
//  - ifid_enable = ~stall in RUN/PEND. ifid_clear = ~stall & ~imem_ready (bubble on memory wait).
//  - RUN, redirect_valid & adv: PC_jump_select=1, jump_addr=redirect_addr. Stay in RUN.
//  - RUN, redirect_valid & ~adv: pend_addr<=redirect_addr -> PEND. PC held, PC_jump_select=0.
//  - PEND: jump_addr=pend_addr, redirect_pend=1.
//    If adv: PC_jump_select=1, PC_enable=1 -> RUN.
//  - PEND, new redirect_valid: newest wins.
//    If adv, issue redirect_addr immediately -> RUN.
//    Else overwrite pend_addr and stay in PEND.
//  - RUN, no redirect: PC_jump_select=0. jump_addr=redirect_addr (don't-care).
//  - jump_addr[1:0] is always forced to 2'b00 (word alignment). Upper bits pass unchanged.
//  - stall & redirect in the same cycle: redirect is latched, never dropped.
//  - Latency: an unblocked redirect reaches the PC at the next clk edge (0 extra cycles).
//    A pended redirect issues on the first adv cycle.
//  - Reset mid-operation: a pended redirect is discarded. BOOT restarts from boot_cnt=0.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: stall_cnt += 1 each RUN/PEND cycle with PC_enable==0.
//    redirect_cnt += 1 each cycle with PC_enable & PC_jump_select.
//    Both counters wrap modulo 2^CNT_W.
//  Not defined: stall_cnt/redirect_cnt ports absent, no counter flops.
// STRUCTURE
//  fetch_pkg: state encoding (BOOT=2'd0, RUN=2'd1, PEND=2'd2) and the ALIGN_MASK constant.
//  One sub-module, fetch_perf_counter (CNT_W-bit enable/sync-clear counter).
//    Instantiated twice under FETCH_PERF_CNT_EN.
//  FSM and redirect latch remain in fetch_sequencer.
// TESTING
//  1. BOOT_CYCLES=2, release reset, stall=0, imem_ready=1.
//     -> PC_enable 0,0 then 1. ifid_clear=1 during BOOT.
//  2. RUN, redirect_valid=1, addr=0x0000_3040, adv=1.
//     -> same cycle PC_jump_select=1, jump_addr=0x3040. Next cycle PC_jump_select=0.
//  3. stall=1 with redirect 0x3100, then stall=0 two cycles later.
//     -> redirect_pend=1 for 2 cycles. On release: PC_enable=1, PC_jump_select=1, jump_addr=0x3100.
//  4. PEND on 0x3100, imem_ready=0, new redirect 0x3200.
//     -> pend_addr=0x3200. Issued 0x3200 when imem_ready=1. 0x3100 never issued.
//  5. imem_ready=0, stall=0.
//     -> PC_enable=0, ifid_enable=1, ifid_clear=1. Redirect 0x3003 -> jump_addr=0x3000.
//  6. PEND active, reset=0 for one edge.
//     -> state BOOT, redirect_pend=0. Counters=0 (FETCH_PERF_CNT_EN); 3 stalled cycles -> stall_cnt=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the IF-stage fetch sequencer: FSM state encoding and jump alignment mask.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } fetch_state_e;

    // Bits set here are forced to zero on every jump target (word alignment).
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_if.sv
// Handshake bundle between hazard unit / ID branch logic (master) and the fetch sequencer (slave).
interface fetch_if #(
    parameter int ADDR_W = 32
) ();
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              imem_ready;
    logic              PC_enable;
    logic              PC_jump_select;
    logic [ADDR_W-1:0] jump_addr;
    logic              ifid_enable;
    logic              ifid_clear;
    logic              redirect_pend;

    modport master (
        output stall, redirect_valid, redirect_addr, imem_ready,
        input  PC_enable, PC_jump_select, jump_addr, ifid_enable, ifid_clear, redirect_pend
    );

    modport slave (
        input  stall, redirect_valid, redirect_addr, imem_ready,
        output PC_enable, PC_jump_select, jump_addr, ifid_enable, ifid_clear, redirect_pend
    );
endinterface

// File: rtl/fetch_perf_counter.sv
// Wrapping event counter with enable; the synchronous active-low reset doubles as its clear.
module fetch_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles, wrapping modulo 2^CNT_W
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage control: boot hold, PC advance/stall, redirect issue and latching of blocked redirects.
// Optional perf counters (stall_cnt, redirect_cnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    fetch_if.slave           bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
`endif
);

    localparam int BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);

    fetch_state_e      state_r, state_nxt_s;
    logic [BCW-1:0]    boot_cnt_r, boot_cnt_nxt_s;
    logic [ADDR_W-1:0] pend_addr_r, pend_addr_nxt_s;

    logic              adv_s;
    logic              pc_en_s;
    logic              sel_s;
    logic [ADDR_W-1:0] jump_raw_s;
    logic              ifid_en_s;
    logic              ifid_clr_s;
    logic              pend_s;

    // State, boot counter and latched redirect target
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_BOOT;
            boot_cnt_r  <= '0;
            pend_addr_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            boot_cnt_r  <= boot_cnt_nxt_s;
            pend_addr_r <= pend_addr_nxt_s;
        end
    end

    // Next-state and output decode; a blocked redirect is never dropped, newest target wins
    always_comb begin
        adv_s           = bus.imem_ready & ~bus.stall;
        state_nxt_s     = state_r;
        boot_cnt_nxt_s  = boot_cnt_r;
        pend_addr_nxt_s = pend_addr_r;
        pc_en_s         = 1'b0;
        sel_s           = 1'b0;
        jump_raw_s      = '0;
        ifid_en_s       = 1'b0;
        ifid_clr_s      = 1'b0;
        pend_s          = 1'b0;

        case (state_r)
            ST_BOOT: begin
                ifid_clr_s = 1'b1;
                if (boot_cnt_r == BOOT_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    boot_cnt_nxt_s = boot_cnt_r + BCW'(1);
                end
            end
            ST_RUN: begin
                pc_en_s    = adv_s;
                ifid_en_s  = ~bus.stall;
                ifid_clr_s = ~bus.stall & ~bus.imem_ready;
                jump_raw_s = bus.redirect_addr;
                if (bus.redirect_valid && adv_s) begin
                    sel_s = 1'b1;
                end else if (bus.redirect_valid) begin
                    pend_addr_nxt_s = bus.redirect_addr;
                    state_nxt_s     = ST_PEND;
                end else begin
                    sel_s = 1'b0;
                end
            end
            ST_PEND: begin
                pc_en_s    = adv_s;
                ifid_en_s  = ~bus.stall;
                ifid_clr_s = ~bus.stall & ~bus.imem_ready;
                pend_s     = 1'b1;
                jump_raw_s = pend_addr_r;
                if (bus.redirect_valid && adv_s) begin
                    sel_s       = 1'b1;
                    jump_raw_s  = bus.redirect_addr;
                    state_nxt_s = ST_RUN;
                end else if (bus.redirect_valid) begin
                    pend_addr_nxt_s = bus.redirect_addr;
                end else if (adv_s) begin
                    sel_s       = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    sel_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    assign bus.PC_enable      = pc_en_s;
    assign bus.PC_jump_select = sel_s;
    assign bus.jump_addr      = {jump_raw_s[ADDR_W-1:2], jump_raw_s[1:0] & ~ALIGN_MASK};
    assign bus.ifid_enable    = ifid_en_s;
    assign bus.ifid_clear     = ifid_clr_s;
    assign bus.redirect_pend  = pend_s;

`ifdef FETCH_PERF_CNT_EN
    logic stall_ev_s;
    logic redir_ev_s;

    assign stall_ev_s = (state_r != ST_BOOT) & ~pc_en_s;
    assign redir_ev_s = pc_en_s & sel_s;

    fetch_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_ev_s),
        .count (stall_cnt)
    );

    fetch_perf_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (redir_ev_s),
        .count (redirect_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed literal scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_fetch_sequencer;
    localparam int ADDR_W      = 32;
    localparam int BOOT_CYCLES = 2;
    localparam int CNT_W       = 32;

    logic clk;
    logic reset;
    fetch_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] redirect_cnt;
`endif

    fetch_sequencer #(.ADDR_W(ADDR_W), .BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: boot cycle count, optional pending target, event counts
    bit          model_ok = 1'b0;
    int          boot_seen;
    bit          pend_v;
    logic [31:0] pend_a;
    longint      m_stalls;
    longint      m_redirs;

    always @(negedge clk) begin
        bit          in_boot, adv, e_en, e_sel, e_ife, e_ifc, e_pend;
        logic [31:0] e_jump;
        bit          n_pend_v;
        logic [31:0] n_pend_a;
        in_boot  = (boot_seen < BOOT_CYCLES);
        adv      = bus.imem_ready && !bus.stall;
        n_pend_v = pend_v;
        n_pend_a = pend_a;
        e_en = 0; e_sel = 0; e_ife = 0; e_ifc = 1; e_pend = 0; e_jump = 32'h0;
        if (!in_boot) begin
            e_en   = adv;
            e_ife  = !bus.stall;
            e_ifc  = !bus.stall && !bus.imem_ready;
            e_pend = pend_v;
            e_jump = pend_v ? pend_a : bus.redirect_addr;
            if (bus.redirect_valid) begin
                if (adv) begin
                    e_sel    = 1;
                    e_jump   = bus.redirect_addr;
                    n_pend_v = 0;
                end else begin
                    n_pend_v = 1;
                    n_pend_a = bus.redirect_addr;
                end
            end else if (pend_v && adv) begin
                e_sel    = 1;
                n_pend_v = 0;
            end
            e_jump = e_jump & 32'hFFFF_FFFC;
        end
        if (model_ok) begin
            chk("PC_enable", 64'(bus.PC_enable), 64'(e_en));
            chk("PC_jump_select", 64'(bus.PC_jump_select), 64'(e_sel));
            chk("jump_addr", 64'(bus.jump_addr), 64'(e_jump));
            chk("ifid_enable", 64'(bus.ifid_enable), 64'(e_ife));
            chk("ifid_clear", 64'(bus.ifid_clear), 64'(e_ifc));
            chk("redirect_pend", 64'(bus.redirect_pend), 64'(e_pend));
`ifdef FETCH_PERF_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stalls % (64'd1 << CNT_W)));
            chk("redirect_cnt", 64'(redirect_cnt), 64'(m_redirs % (64'd1 << CNT_W)));
`endif
        end
        if (!reset) begin
            model_ok  = 1'b1;
            boot_seen = 0;
            pend_v    = 1'b0;
            pend_a    = 32'h0;
            m_stalls  = 0;
            m_redirs  = 0;
        end else if (model_ok) begin
            if (in_boot) begin
                boot_seen++;
            end else begin
                if (!e_en) m_stalls++;
                if (e_en && e_sel) m_redirs++;
                pend_v = n_pend_v;
                pend_a = n_pend_a;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rv, input logic [31:0] ra, input logic rdy);
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_addr  = ra;
        bus.imem_ready     = rdy;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        step(); step();
        // Boot hold after reset release
        reset = 1'b1;
        #2 chk("boot0_pc_en", 64'(bus.PC_enable), 64'd0);
        chk("boot0_ifid_clear", 64'(bus.ifid_clear), 64'd1);
        step(); #1 chk("boot1_pc_en", 64'(bus.PC_enable), 64'd0);
        step(); #1 chk("run_pc_en", 64'(bus.PC_enable), 64'd1);
        // Unblocked redirect
        drive(1'b0, 1'b1, 32'h0000_3040, 1'b1);
        #1 chk("redir_sel", 64'(bus.PC_jump_select), 64'd1);
        chk("redir_addr", 64'(bus.jump_addr), 64'h3040);
        step(); drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1 chk("redir_after_sel", 64'(bus.PC_jump_select), 64'd0);
        // Redirect during stall
        drive(1'b1, 1'b1, 32'h0000_3100, 1'b1);
        #1 chk("stall_pc_en", 64'(bus.PC_enable), 64'd0);
        step(); drive(1'b1, 1'b0, 32'h0, 1'b1);
        #1 chk("pend_a", 64'(bus.redirect_pend), 64'd1);
        step(); #1 chk("pend_b", 64'(bus.redirect_pend), 64'd1);
        step(); drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1 chk("release_pc_en", 64'(bus.PC_enable), 64'd1);
        chk("release_sel", 64'(bus.PC_jump_select), 64'd1);
        chk("release_addr", 64'(bus.jump_addr), 64'h3100);
        step(); #1 chk("release_done", 64'(bus.redirect_pend), 64'd0);
        // Newest pending redirect wins
        drive(1'b0, 1'b1, 32'h0000_3100, 1'b0);
        step(); drive(1'b0, 1'b1, 32'h0000_3200, 1'b0);
        #1 chk("pend_old_addr", 64'(bus.jump_addr), 64'h3100);
        chk("pend_old_sel", 64'(bus.PC_jump_select), 64'd0);
        step(); drive(1'b0, 1'b0, 32'h0, 1'b1);
        #1 chk("newest_sel", 64'(bus.PC_jump_select), 64'd1);
        chk("newest_addr", 64'(bus.jump_addr), 64'h3200);
        step();
        // Memory wait bubble and alignment
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #1 chk("wait_pc_en", 64'(bus.PC_enable), 64'd0);
        chk("wait_ifid_en", 64'(bus.ifid_enable), 64'd1);
        chk("wait_ifid_clr", 64'(bus.ifid_clear), 64'd1);
        drive(1'b0, 1'b1, 32'h0000_3003, 1'b1);
        #1 chk("align_addr", 64'(bus.jump_addr), 64'h3000);
        step();
        // Reset discards a pending redirect
        drive(1'b1, 1'b1, 32'h0000_3300, 1'b1);
        step(); drive(1'b1, 1'b0, 32'h0, 1'b1);
        #1 chk("pre_reset_pend", 64'(bus.redirect_pend), 64'd1);
        reset = 1'b0;
        step(); reset = 1'b1;
        #1 chk("post_reset_pend", 64'(bus.redirect_pend), 64'd0);
        chk("post_reset_clr", 64'(bus.ifid_clear), 64'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("post_reset_scnt", 64'(stall_cnt), 64'd0);
        chk("post_reset_rcnt", 64'(redirect_cnt), 64'd0);
`endif
        step(); step(); step(); step(); step();
        #1 chk("stalled_pc_en", 64'(bus.PC_enable), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt_3", 64'(stall_cnt), 64'd3);
`endif
        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                  $urandom, ($urandom_range(0, 9) < 7));
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
